fetch_unit: RTL and testbench

Instruction-fetch front end that owns the program counter and consumes the next-PC redirect (`pcSrc`/`targetAddr`) produced by branch/jump resolution. It issues in-order requests to instruction memory over a valid/ready handshake, pairs each returned word with its PC, and buffers the pairs for the decode stage. It sits between the PC-select logic and decode, and discards in-flight fetches on a redirect.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous flush; storage clears on reset so the
// head reads as zero until the first push.
import riscv_pkg::*;

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited in-order
// fetches, tags returned words with their PC and drops stale ones on redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] targetAddr,
  output logic            imemReqValid,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemRespValid,
  input  logic [XLEN-1:0] imemRespData,
  output logic            instValid,
  output logic [XLEN-1:0] instData,
  output logic [XLEN-1:0] instPc,
  input  logic            instReady
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   queue_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            req_fire;
  logic            keep_resp;
  logic            inst_pop;

  // Outstanding plus buffered fetches never exceed DEPTH, so every response has a slot.
  assign credit_used  = (CW+1)'(inflight) + (CW+1)'(queue_count);
  assign imemReqValid = !rst && !pcSrc && (credit_used < (CW+1)'(DEPTH));
  assign req_fire     = imemReqValid && imemReqReady;
  assign keep_resp    = imemRespValid && !pcSrc && (drop_cnt == '0);
  assign inst_pop     = instValid && instReady && !pcSrc;
  assign push_entry   = '{pc: tag_head, inst: imemRespData};

  assign imemReqAddr = pc;
  assign instValid   = (queue_count != '0);
  assign instData    = head_entry.inst;
  assign instPc      = head_entry.pc;

  // The tag FIFO occupancy doubles as the in-flight request count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imemRespValid),
    .head      (tag_head),
    .count     (inflight)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) inst_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (pcSrc),
    .push      (keep_resp),
    .push_data (push_entry),
    .pop       (inst_pop),
    .head      (head_entry),
    .count     (queue_count)
  );

  // A redirect arms drop_cnt with every fetch still owed except one returning now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (pcSrc) begin
      pc       <= targetAddr;
      drop_cnt <= inflight - CW'(imemRespValid);
    end else begin
      if (req_fire) pc <= pc + XLEN'(INST_BYTES);
      if (imemRespValid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, an in-order
// latency-randomised memory, a directed table and multi-cycle corner sequences.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcSrc;
  logic [31:0] targetAddr;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pcSrc         (pcSrc),
    .targetAddr    (targetAddr),
    .imemReqValid  (imemReqValid),
    .imemReqReady  (imemReqReady),
    .imemReqAddr   (imemReqAddr),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .instValid     (instValid),
    .instData      (instData),
    .instPc        (instPc),
    .instReady     (instReady)
  );

  typedef struct {int due; logic [31:0] data;} resp_t;
  typedef struct {logic [31:0] addr; bit drop;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} pair_t;
  typedef struct {
    bit src; logic [31:0] tgt; bit rdy; bit irdy;
    bit e_rv; logic [31:0] e_addr; bit e_iv; logic [31:0] e_ipc;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int last_due;
  int lat_min = 1;
  int lat_max = 1;
  resp_t mem_q[$];
  pend_t pend[$];
  pair_t iq[$];
  logic [31:0] m_pc;
  bit exp_rv;
  bit dut_fire;
  logic [31:0] dut_addr;
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  vec_t tbl[6];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    iq.delete();
    mem_q.delete();
    m_pc = RESET_PC;
    last_due = 0;
    cyc = 1;
  endtask

  // Asserts reset, checks outputs immediately, then releases right after an edge.
  task automatic doReset();
    rst = 1'b1;
    pcSrc = 1'b0;
    targetAddr = '0;
    imemReqReady = 1'b0;
    instReady = 1'b0;
    imemRespValid = 1'b0;
    imemRespData = '0;
    #1;
    check("rst_imemReqValid", 32'(imemReqValid), 32'd0);
    check("rst_imemReqAddr", imemReqAddr, RESET_PC);
    check("rst_instValid", 32'(instValid), 32'd0);
    check("rst_instData", instData, 32'd0);
    check("rst_instPc", instPc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input bit src, input logic [31:0] tgt, input bit rdy, input bit irdy);
    pcSrc = src;
    targetAddr = tgt;
    imemReqReady = rdy;
    instReady = irdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData = mem_q[0].data;
    end else begin
      imemRespValid = 1'b0;
      imemRespData = $urandom;
    end
    #2;
    exp_rv = !pcSrc && (pend.size() + iq.size() < DEPTH);
    dut_fire = imemReqValid && imemReqReady;
    dut_addr = imemReqAddr;
  endtask

  task automatic checkOutput();
    check("imemReqValid", 32'(imemReqValid), 32'(exp_rv));
    check("imemReqAddr", imemReqAddr, m_pc);
    check("instValid", 32'(instValid), 32'(iq.size() > 0));
    if (iq.size() > 0) begin
      check("instPc", instPc, iq[0].pc);
      check("instData", instData, iq[0].inst);
    end
  endtask

  task automatic endCycle();
    bit resp;
    bit m_fire;
    pend_t e;
    int d;
    resp = imemRespValid;
    m_fire = exp_rv && imemReqReady;
    if (instValid && instReady && !pcSrc) pop_log.push_back(instPc);
    @(posedge clk);
    #1;
    if (resp) void'(mem_q.pop_front());
    if (dut_fire) begin
      fire_log.push_back(dut_addr);
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{due: d, data: memWord(dut_addr)});
    end
    // Reference behaviour: redirect marks every owed fetch stale and empties the queue.
    if (pcSrc) begin
      if (resp && pend.size() > 0) void'(pend.pop_front());
      foreach (pend[i]) pend[i].drop = 1'b1;
      iq.delete();
      m_pc = targetAddr;
    end else begin
      if (iq.size() > 0 && instReady) void'(iq.pop_front());
      if (resp && pend.size() > 0) begin
        e = pend.pop_front();
        if (!e.drop) iq.push_back('{pc: e.addr, inst: memWord(e.addr)});
      end
      if (m_fire) begin
        pend.push_back('{addr: m_pc, drop: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic runCycle(input bit src, input logic [31:0] tgt, input bit rdy, input bit irdy);
    applyStimulus(src, tgt, rdy, irdy);
    checkOutput();
    endCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    tbl[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

    rst = 1'b1;
    doReset();

    // Streaming from reset with single-cycle memory and an always-ready decode.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].src, tbl[i].tgt, tbl[i].rdy, tbl[i].irdy);
      checkOutput();
      check("tbl_reqValid", 32'(imemReqValid), 32'(tbl[i].e_rv));
      check("tbl_reqAddr", imemReqAddr, tbl[i].e_addr);
      check("tbl_instValid", 32'(instValid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        check("tbl_instPc", instPc, tbl[i].e_ipc);
        check("tbl_instData", instData, memWord(tbl[i].e_ipc));
      end
      endCycle();
    end

    // Decode stall: only DEPTH fetches go out, then fetching resumes in order.
    doReset();
    fire_log.delete();
    for (int i = 0; i < 10; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("stall_fire_count", fire_log.size(), DEPTH);
    fire_log.delete();
    for (int i = 0; i < 6 && fire_log.size() == 0; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("stall_resume_seen", fire_log.size(), 1);
    if (fire_log.size() > 0) check("stall_resume_addr", fire_log[0], 32'(4 * DEPTH));

    // Redirect to 0x100 while 0x8 and 0xC are owed (0x8 returns in the redirect cycle).
    doReset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 5; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    pop_log.delete();
    runCycle(1'b1, 32'h100, 1'b1, 1'b1);
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("redir_pop_count", pop_log.size() >= 2 ? 32'd2 : pop_log.size(), 32'd2);
    if (pop_log.size() >= 2) begin
      check("redir_pc0", pop_log[0], 32'h100);
      check("redir_pc1", pop_log[1], 32'h104);
    end

    // Redirect coinciding with a response and a decode pop.
    doReset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    pop_log.delete();
    runCycle(1'b1, 32'h200, 1'b1, 1'b1);
    for (int i = 0; i < 20 && pop_log.size() < 3; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("same_cycle_pop_count", pop_log.size() >= 3 ? 32'd3 : pop_log.size(), 32'd3);
    if (pop_log.size() >= 3) begin
      check("same_cycle_pc0", pop_log[0], 32'h200);
      check("same_cycle_pc1", pop_log[1], 32'h204);
      check("same_cycle_pc2", pop_log[2], 32'h208);
    end

    // PC wraps from the top of the address space to zero.
    doReset();
    runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    fire_log.delete();
    runCycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 20 && fire_log.size() < 3; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("wrap_fire_count", fire_log.size() >= 3 ? 32'd3 : fire_log.size(), 32'd3);
    if (fire_log.size() >= 3) begin
      check("wrap_addr0", fire_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", fire_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", fire_log[2], 32'h0000_0000);
    end

    // Reset mid-operation with a filling queue and requests outstanding.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) runCycle(1'b0, 32'h0, 1'b1, 1'b0);
    doReset();
    fire_log.delete();
    runCycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("post_rst_fire_count", fire_log.size(), 1);
    if (fire_log.size() > 0) check("post_rst_addr", fire_log[0], RESET_PC);

    // Randomised traffic against the reference model.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      runCycle($urandom_range(99) < 6, r & ~32'h3, $urandom_range(99) < 75, $urandom_range(99) < 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
